// File: rtl/led_code_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_code_ctrl_if
// Brief    : Heartbeat, error-code and LED status signals of the LED stage.
// Revision : 1.0 - initial release
// ============================================================================
interface led_code_ctrl_if;
    logic       heartbeat_in;
    logic [2:0] err_code;
    logic       err_valid;
    logic       err_clr;
    logic       led_out;
    logic       busy;
    logic [2:0] code_active;

    modport master (
        output heartbeat_in, err_code, err_valid, err_clr,
        input  led_out, busy, code_active
    );

    modport slave (
        input  heartbeat_in, err_code, err_valid, err_clr,
        output led_out, busy, code_active
    );
endinterface
`default_nettype wire

// File: rtl/led_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_code_ctrl
// Brief    : Status-LED driver: heartbeat pass-through or repeating blink code.
// Revision : 1.0 - initial release
// ============================================================================
module led_code_ctrl #(
    parameter logic [24:0] TICK_DIV  = 25'd12500000,
    parameter logic [3:0]  ON_TICKS  = 4'd1,
    parameter logic [3:0]  OFF_TICKS = 4'd1,
    parameter logic [3:0]  GAP_TICKS = 4'd4,
    parameter logic        LED_ON    = 1'b0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    led_code_ctrl_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ON   = 2'd1;
    localparam logic [1:0] c_OFF  = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;

    logic [24:0] cnt_q;
    logic [2:0]  latch_q;
    logic [1:0]  state_q,  state_d;
    logic [3:0]  phase_q,  phase_d;
    logic [2:0]  rem_q,    rem_d;
    logic        led_q,    led_d;
    logic        busy_q,   busy_d;
    logic [2:0]  code_q,   code_d;
    logic        w_tick;

    // Free-running prescaler; FSM activity never restarts it.
    assign w_tick = (cnt_q == TICK_DIV - 25'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 25'd0;
        end else if (w_tick) begin
            cnt_q <= 25'd0;
        end else begin
            cnt_q <= cnt_q + 25'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_q <= 3'd0;
        end else if (bus.err_valid && (bus.err_code != 3'd0)) begin
            latch_q <= bus.err_code;
        end else if (bus.err_clr) begin
            latch_q <= 3'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        led_d   = led_q;
        busy_d  = busy_q;
        code_d  = code_q;
        if (w_tick) begin
            phase_d = phase_q + 4'd1;
        end
        case (state_q)
            c_IDLE: begin
                led_d = bus.heartbeat_in;
                if (w_tick && (latch_q != 3'd0)) begin
                    state_d = c_ON;
                    code_d  = latch_q;
                    rem_d   = latch_q;
                    busy_d  = 1'b1;
                    led_d   = LED_ON;
                end
            end
            c_ON: begin
                if (w_tick && (phase_q == ON_TICKS - 4'd1)) begin
                    rem_d   = rem_q - 3'd1;
                    state_d = c_OFF;
                    led_d   = ~LED_ON;
                end
            end
            c_OFF: begin
                if (w_tick && (phase_q == OFF_TICKS - 4'd1)) begin
                    if (rem_q != 3'd0) begin
                        state_d = c_ON;
                        led_d   = LED_ON;
                    end else begin
                        state_d = c_GAP;
                    end
                end
            end
            c_GAP: begin
                // A code loaded mid-sequence is picked up only here.
                if (w_tick && (phase_q == GAP_TICKS - 4'd1)) begin
                    if (latch_q == 3'd0) begin
                        state_d = c_IDLE;
                        busy_d  = 1'b0;
                        code_d  = 3'd0;
                        led_d   = bus.heartbeat_in;
                    end else begin
                        state_d = c_ON;
                        code_d  = latch_q;
                        rem_d   = latch_q;
                        led_d   = LED_ON;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                busy_d  = 1'b0;
                code_d  = 3'd0;
                led_d   = ~LED_ON;
            end
        endcase
        if (state_d != state_q) begin
            phase_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
            phase_q <= 4'd0;
            rem_q   <= 3'd0;
            led_q   <= ~LED_ON;
            busy_q  <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            code_q  <= code_d;
        end
    end

    assign bus.led_out     = led_q;
    assign bus.busy        = busy_q;
    assign bus.code_active = code_q;

endmodule
`default_nettype wire

// File: tb/tb_led_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_code_ctrl
// Brief    : Self-checking bench for led_code_ctrl against a tick-slot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_code_ctrl;

    localparam int TD  = 4;
    localparam int ONT = 1;
    localparam int OFT = 1;
    localparam int GPT = 4;
    localparam logic LON = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    led_code_ctrl_if bus ();

    led_code_ctrl #(
        .TICK_DIV (25'(TD)),
        .ON_TICKS (4'(ONT)),
        .OFF_TICKS(4'(OFT)),
        .GAP_TICKS(4'(GPT)),
        .LED_ON   (LON)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lows  = 0;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one LED level per tick period, a whole repetition queued at once.
    int         cyc     = 0;
    logic [2:0] m_latch = 3'd0;
    logic [2:0] m_code  = 3'd0;
    logic       m_led   = 1'b1;
    logic       m_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc     = 0;
            m_latch = 3'd0;
            m_code  = 3'd0;
            m_led   = ~LON;
            m_q.delete();
        end else begin
            if ((cyc % TD) == TD - 1) begin
                if (m_q.size() == 0 && m_latch != 3'd0) begin
                    m_code = m_latch;
                    for (int f = 0; f < int'(m_latch); f++) begin
                        for (int k = 0; k < ONT; k++) m_q.push_back(LON);
                        for (int k = 0; k < OFT; k++) m_q.push_back(~LON);
                    end
                    for (int k = 0; k < GPT; k++) m_q.push_back(~LON);
                end
                if (m_q.size() != 0) begin
                    m_led = m_q.pop_front();
                end else begin
                    m_code = 3'd0;
                    m_led  = bus.heartbeat_in;
                end
            end else if (m_code == 3'd0) begin
                m_led = bus.heartbeat_in;
            end
            cyc++;
            if (bus.err_valid && bus.err_code != 3'd0) m_latch = bus.err_code;
            else if (bus.err_clr)                      m_latch = 3'd0;
        end
    end

    always @(negedge clk) begin
        chk("led_out", {2'b0, bus.led_out}, {2'b0, m_led});
        chk("busy", {2'b0, bus.busy}, {2'b0, (m_code != 3'd0)});
        chk("code_active", bus.code_active, m_code);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.led_out == 1'b0) lows++;
        end
    endtask

    task automatic wait_busy(input logic v, input int lim, input string name);
        int n = 0;
        while (bus.busy !== v && n < lim) begin
            step(1);
            n++;
        end
        if (n >= lim) chk(name, {2'b0, bus.busy}, {2'b0, v});
    endtask

    task automatic wait_code(input logic [2:0] v, input int lim, input string name);
        int n = 0;
        while (bus.code_active !== v && n < lim) begin
            step(1);
            n++;
        end
        if (n >= lim) chk(name, bus.code_active, v);
    endtask

    task automatic pulse(input logic [2:0] code, input logic v, input logic c);
        bus.err_code  = code;
        bus.err_valid = v;
        bus.err_clr   = c;
        step(1);
        bus.err_valid = 1'b0;
        bus.err_clr   = 1'b0;
        bus.err_code  = 3'd0;
    endtask

    initial begin
        bus.heartbeat_in = 1'b0;
        bus.err_code     = 3'd0;
        bus.err_valid    = 1'b0;
        bus.err_clr      = 1'b0;

        // Reset held with heartbeat toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.heartbeat_in = ~bus.heartbeat_in;
        end
        chk("reset_led", {2'b0, bus.led_out}, 3'd1);
        chk("reset_busy", {2'b0, bus.busy}, 3'd0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.heartbeat_in = (i % 3 == 0);
            step(1);
        end
        bus.heartbeat_in = 1'b0;
        step(2);
        chk("hb_track_0", {2'b0, bus.led_out}, 3'd0);

        // Code 0 is ignored
        pulse(3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.heartbeat_in = i[0];
            step(1);
        end
        chk("code0_busy", {2'b0, bus.busy}, 3'd0);

        // Code 3: 12 lit cycles in a 40-cycle period
        bus.heartbeat_in = 1'b1;
        pulse(3'd3, 1'b1, 1'b0);
        wait_busy(1'b1, 10, "busy_rise_timeout");
        chk("code3_active", bus.code_active, 3'd3);
        lows = (bus.led_out == 1'b0) ? 1 : 0;
        step(39);
        chk("code3_lows", 3'(lows), 3'd12 & 3'h7);
        chk("code3_lows_full", (lows == 12) ? 3'd1 : 3'd0, 3'd1);
        step(1);
        chk("code3_period", {2'b0, bus.led_out}, 3'd0);

        // Load code 1 during the 2nd flash of this repetition
        step(8);
        pulse(3'd1, 1'b1, 1'b0);
        chk("code3_kept", bus.code_active, 3'd3);
        wait_code(3'd1, 60, "code1_timeout");
        lows = (bus.led_out == 1'b0) ? 1 : 0;
        step(23);
        chk("code1_lows", 3'(lows), 3'd4);
        step(1);
        chk("code1_period", {2'b0, bus.led_out}, 3'd0);

        // err_clr during the 1st flash of code 2
        pulse(3'd2, 1'b1, 1'b0);
        wait_code(3'd2, 60, "code2_timeout");
        lows = 0;
        pulse(3'd0, 1'b0, 1'b1);
        wait_busy(1'b0, 60, "busy_fall_timeout");
        chk("clr_lows", 3'(lows), 3'd7);
        chk("clr_code", bus.code_active, 3'd0);
        bus.heartbeat_in = 1'b0;
        step(2);
        chk("clr_hb0", {2'b0, bus.led_out}, 3'd0);
        bus.heartbeat_in = 1'b1;
        step(2);
        chk("clr_hb1", {2'b0, bus.led_out}, 3'd1);

        // err_valid(5) with err_clr in the same cycle
        pulse(3'd5, 1'b1, 1'b1);
        wait_busy(1'b1, 10, "code5_timeout");
        chk("code5_active", bus.code_active, 3'd5);
        lows = (bus.led_out == 1'b0) ? 1 : 0;
        step(55);
        chk("code5_lows_full", (lows == 20) ? 3'd1 : 3'd0, 3'd1);
        step(1);

        // Async reset mid-flash
        chk("pre_rst_led", {2'b0, bus.led_out}, 3'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_led", {2'b0, bus.led_out}, 3'd1);
        chk("async_busy", {2'b0, bus.busy}, 3'd0);
        chk("async_code", bus.code_active, 3'd0);
        step(3);
        rst = 1'b1;
        lows = 0;
        step(60);
        chk("post_rst_lows", 3'(lows), 3'd0);
        chk("post_rst_busy", {2'b0, bus.busy}, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_code_ctrl.md
Name: led_code_ctrl

Overview:
Status-LED output stage for sig_acq. Sits directly downstream of the heartbeat blinker and drives the board LED pin. With no error latched it passes the heartbeat through. Once a nonzero error code is latched it overrides the heartbeat with a repeating blink code: N flashes, then a long gap, where N is the error code.

Parameters:
TICK_DIV, 25'd12500000, clk cycles per time tick (250 ms at 50 MHz); legal range 2..2^25-1
ON_TICKS, 4'd1, ticks the LED is lit per flash; legal range 1..15
OFF_TICKS, 4'd1, ticks the LED is dark between flashes; legal range 1..15
GAP_TICKS, 4'd4, ticks the LED is dark after the last flash of a code; legal range 1..15
LED_ON, 1'b0, output level that lights the LED (active-low LED)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
heartbeat_in  input  1  heartbeat level from the blinker, shown while idle
err_code  input  3  error code, 1..7; 0 means "no error"
err_valid  input  1  single-cycle strobe; latches err_code
err_clr  input  1  single-cycle strobe; clears the latched error
led_out  output  1  LED pin drive (registered)
busy  output  1  high while a blink-code sequence is running
code_active  output  3  code currently being displayed; 0 when idle

Behaviour:
- Reset (rst low, async):
  - led_out = ~LED_ON, busy = 0, code_active = 0.
  - Latched code = 0, tick counter = 0, state = IDLE.
- Tick prescaler:
  - 25-bit counter runs freely 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when count == TICK_DIV-1.
  - The counter is never reset by FSM activity.
- Code latch:
  - err_valid with err_code != 0 loads err_code. err_valid with err_code == 0 is ignored.
  - err_clr clears the latch to 0.
  - err_valid and err_clr in the same cycle: err_valid wins.
- FSM states: IDLE, ON, OFF, GAP.
  - A 4-bit phase counter counts ticks within a state and is cleared on every state change.
  - A 3-bit remaining-flash counter tracks flashes left in the current code.
  - All state transitions occur only on a tick cycle.
- IDLE:
  - led_out <= heartbeat_in (1-cycle latency); busy = 0; code_active = 0.
  - On tick with latch != 0: code_active <= latch, remaining <= latch, go to ON.
- ON:
  - led_out = LED_ON.
  - On tick with phase == ON_TICKS-1: decrement remaining, go to OFF.
- OFF:
  - led_out = ~LED_ON.
  - On tick with phase == OFF_TICKS-1: go to ON if remaining != 0, else go to GAP.
- GAP:
  - led_out = ~LED_ON.
  - On tick with phase == GAP_TICKS-1:
    - latch == 0: go to IDLE.
    - latch != 0: reload code_active and remaining from the latch, go to ON.
- Timing:
  - led_out, busy and code_active are registered.
  - They change on the same clock edge as the state register, i.e. the edge where tick = 1.
- Code change mid-sequence: the new code is latched immediately but displayed only from the next repetition (after GAP). The current flash count is never altered.
- err_clr mid-sequence: the current code finishes through GAP, then the FSM returns to IDLE. There is no truncation.
- Heartbeat is ignored in all states except IDLE.

Test Plan:
(Bench parameters: TICK_DIV=4, ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=4, LED_ON=0.)
- Reset held, heartbeat toggling -> led_out=1, busy=0, code_active=0. After release with no error, led_out follows heartbeat_in delayed 1 cycle.
- err_valid with code 3 -> at the next tick busy=1 and code_active=3. led_out repeats: 0 for 4 clk, 1 for 4 clk, three times, then 1 for 16 clk more (gap). Full period 40 clk.
- err_valid with code 0 while idle -> no state change, busy stays 0, led_out keeps tracking the heartbeat.
- During the 2nd flash of code 3, load code 1 -> the current repetition still shows 3 flashes. The next repetition shows 1 flash (period 24 clk) and code_active=1.
- err_clr during the 1st flash of code 2 -> both flashes and the 16-clk gap complete, then state = IDLE, busy=0 and led_out tracks the heartbeat again.
- err_valid (code 5) and err_clr in the same cycle -> latch=5 and the sequence starts with 5 flashes. Separately, assert rst mid-flash -> led_out=1 and busy=0 immediately (async); no further flashes after release.
